mpt_mem_arbiter: RTL and testbench
==================================

Name: mpt_mem_arbiter

Overview:
- Downstream neighbour of the per-unit MPT walkers (load, store, IFU, PTW).
- Merges NumPorts MEM-protocol master buses into one MEM master bus that feeds a single MEM-to-D$ converter, so all walkers share one D$ port.
- Round-robin request arbitration with grant lock; in-order response routing via an ID FIFO, allowing up to MaxOutstanding transactions in flight.

Parameters:
- NumPorts, 4, number of upstream walker MEM buses (>=2).
- AddrWidth, 64, MEM address width.
- DataWidth, 64, MEM data width; byte enables are DataWidth/8.
- MaxOutstanding, 2, ID FIFO depth, i.e. max accepted-but-unanswered requests (power of 2, >=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_mem_req  in  NumPorts  per-port request
- s_mem_gnt  out  NumPorts  per-port grant
- s_mem_addr  in  NumPorts*AddrWidth  per-port address, port i at slice i
- s_mem_wdata  in  NumPorts*DataWidth  per-port write data
- s_mem_we  in  NumPorts  per-port write enable
- s_mem_be  in  NumPorts*DataWidth/8  per-port byte enables
- s_mem_valid  out  NumPorts  per-port response valid
- s_mem_rdata  out  DataWidth  response data, broadcast to all ports
- s_mem_error  out  NumPorts  per-port response error
- m_mem_req  out  1  downstream request
- m_mem_gnt  in  1  downstream grant
- m_mem_addr  out  AddrWidth  downstream address
- m_mem_wdata  out  DataWidth  downstream write data
- m_mem_we  out  1  downstream write enable
- m_mem_be  out  DataWidth/8  downstream byte enables
- m_mem_valid  in  1  downstream response valid (in order)
- m_mem_rdata  in  DataWidth  downstream response data
- m_mem_error  in  1  downstream response error
- busy_o  out  1  FIFO not empty or lock held
- spurious_rsp_o  out  1  sticky: m_mem_valid seen with empty FIFO

Behaviour:
- Reset state: rr_ptr=0, lock cleared, FIFO empty, spurious_rsp_o=0. All outputs 0 while FIFO is empty and no s_mem_req is high.
- Arbitration:
  - If lock is clear, winner = first requesting port at or after rr_ptr, searching cyclically. If lock is set, winner = locked index.
  - m_mem_req = (lock | any s_mem_req) & !fifo_full.
  - m_mem_addr, wdata, we and be are muxed combinationally from the winner. Zero latency, no added cycle.
- Lock:
  - When m_mem_req=1 and m_mem_gnt=0, lock is set to the winner on the next edge.
  - Lock is held until the handshake completes.
  - Upstream masters must keep req and payload stable until granted. The arbiter never switches winner mid-request.
- Handshake (m_mem_req & m_mem_gnt):
  - s_mem_gnt[winner]=1, all other gnt bits 0.
  - Winner index is pushed into the FIFO.
  - rr_ptr <= (winner+1) mod NumPorts.
  - Lock is cleared.
- Full FIFO:
  - m_mem_req is forced to 0 even if a pop occurs in the same cycle. There is no push-through on full.
  - Lock is kept if it was already set.
- Response:
  - On m_mem_valid with FIFO non-empty: s_mem_valid[head]=1, s_mem_error[head]=m_mem_error, FIFO pops. Same cycle, combinational.
  - s_mem_rdata = m_mem_rdata at all times.
- Simultaneous push and pop (not full): both occur; occupancy is unchanged.
- Spurious response: m_mem_valid with empty FIFO is dropped. No s_mem_valid is raised; spurious_rsp_o is set and held until reset.
- Reset mid-operation: FIFO and lock are discarded immediately (asynchronous). In-flight downstream responses after reset are treated as spurious.
- Widths: FIFO entries are $clog2(NumPorts) bits. Pointers are $clog2(MaxOutstanding) bits and wrap naturally. The count register is one bit wider.

Test Plan:
- Single port: s_mem_req[2]=1, addr=0x8000_1000, gnt same cycle -> m_mem_addr=0x8000_1000, s_mem_gnt=4'b0100. Response rdata=0xDEAD_BEEF next cycle -> s_mem_valid=4'b0100 with that rdata.
- All 4 ports request continuously, m_mem_gnt=1, response 1 cycle after each grant -> grant order 0,1,2,3,0. No port is granted twice before every other requester has been granted once.
- Port 1 requests, m_mem_gnt=0 for 3 cycles, port 0 raises req in cycle 2 -> m_mem_addr stays on port 1. Port 1 is granted first, port 0 next.
- MaxOutstanding=2, grants to ports 3 then 0, no response -> m_mem_req=0 while port 1 requests. Responses (err=1, then err=0) -> s_mem_error[3]=1, then s_mem_valid[0]=1 with s_mem_error[0]=0. Port 1 is granted after the first pop.
- Simultaneous push/pop with FIFO at 1 entry -> occupancy stays 1, busy_o stays 1.
- m_mem_valid with empty FIFO -> no s_mem_valid asserted, spurious_rsp_o=1. Assert rst_ni low mid-transaction -> all outputs 0 and spurious_rsp_o cleared.

Source files
------------

// File: rtl/mpt_mem_arbiter.sv
// mpt_mem_arbiter: merges several walker MEM buses into one downstream MEM bus with
// round-robin arbitration, grant lock and in-order response routing through an ID FIFO.
module mpt_mem_arbiter #(
  parameter int NumPorts       = 4,
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumPorts-1:0]             s_mem_req,
  output logic [NumPorts-1:0]             s_mem_gnt,
  input  logic [NumPorts*AddrWidth-1:0]   s_mem_addr,
  input  logic [NumPorts*DataWidth-1:0]   s_mem_wdata,
  input  logic [NumPorts-1:0]             s_mem_we,
  input  logic [NumPorts*DataWidth/8-1:0] s_mem_be,
  output logic [NumPorts-1:0]             s_mem_valid,
  output logic [DataWidth-1:0]            s_mem_rdata,
  output logic [NumPorts-1:0]             s_mem_error,
  output logic                            m_mem_req,
  input  logic                            m_mem_gnt,
  output logic [AddrWidth-1:0]            m_mem_addr,
  output logic [DataWidth-1:0]            m_mem_wdata,
  output logic                            m_mem_we,
  output logic [DataWidth/8-1:0]          m_mem_be,
  input  logic                            m_mem_valid,
  input  logic [DataWidth-1:0]            m_mem_rdata,
  input  logic                            m_mem_error,
  output logic                            busy_o,
  output logic                            spurious_rsp_o
);
  localparam int IW = $clog2(NumPorts);
  localparam int PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int BW = DataWidth / 8;
  logic [IW-1:0] rr_ptr, lock_idx, rr_win, winner, head, j;
  logic [IW-1:0] fifo [MaxOutstanding];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          lock, found, active, full, empty, push, pop, spurious;
  always_comb begin
    rr_win = rr_ptr;
    found  = 1'b0;
    j      = '0;
    for (int k = 0; k < NumPorts; k++) begin
      j = IW'((int'(rr_ptr) + k) % NumPorts);
      if (!found && s_mem_req[j]) begin
        found  = 1'b1;
        rr_win = j;
      end
    end
  end
  // A locked request keeps its winner so the payload never switches mid-request.
  assign winner      = lock ? lock_idx : rr_win;
  assign active      = lock | (|s_mem_req);
  assign full        = count == (PW+1)'(MaxOutstanding);
  assign empty       = count == '0;
  assign m_mem_req   = active & !full;
  assign m_mem_addr  = active ? s_mem_addr[int'(winner)*AddrWidth +: AddrWidth] : '0;
  assign m_mem_wdata = active ? s_mem_wdata[int'(winner)*DataWidth +: DataWidth] : '0;
  assign m_mem_we    = active & s_mem_we[winner];
  assign m_mem_be    = active ? s_mem_be[int'(winner)*BW +: BW] : '0;
  assign push        = m_mem_req & m_mem_gnt;
  assign pop         = m_mem_valid & !empty;
  assign head        = fifo[rd_ptr];
  assign s_mem_gnt   = NumPorts'(push) << winner;
  assign s_mem_valid = NumPorts'(pop) << head;
  assign s_mem_error = NumPorts'(pop & m_mem_error) << head;
  assign s_mem_rdata = m_mem_rdata;
  assign busy_o         = !empty | lock;
  assign spurious_rsp_o = spurious;
  always_ff @(posedge clk_i)
    if (push) fifo[wr_ptr] <= winner;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      spurious <= 1'b0;
    end else begin
      if (push) begin
        lock   <= 1'b0;
        rr_ptr <= (winner == IW'(NumPorts - 1)) ? '0 : winner + 1'b1;
        wr_ptr <= wr_ptr + PW'(MaxOutstanding > 1);
      end else if (m_mem_req) begin
        lock     <= 1'b1;
        lock_idx <= winner;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(MaxOutstanding > 1);
      if (m_mem_valid && empty) spurious <= 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: tb/tb_mpt_mem_arbiter.sv
// tb_mpt_mem_arbiter: directed checks of arbitration order, grant lock, full-FIFO
// stall, in-order response routing, spurious responses and asynchronous reset.
module tb_mpt_mem_arbiter;
  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [3:0]   s_mem_req, s_mem_gnt, s_mem_we, s_mem_valid, s_mem_error;
  logic [255:0] s_mem_addr, s_mem_wdata;
  logic [31:0]  s_mem_be;
  logic [63:0]  s_mem_rdata, m_mem_addr, m_mem_wdata, m_mem_rdata;
  logic         m_mem_req, m_mem_gnt, m_mem_we, m_mem_valid, m_mem_error;
  logic [7:0]   m_mem_be;
  logic         busy_o, spurious_rsp_o;
  int           n_cmp = 0;
  int           n_bad = 0;

  mpt_mem_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_mem_req(s_mem_req), .s_mem_gnt(s_mem_gnt), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_we(s_mem_we), .s_mem_be(s_mem_be),
    .s_mem_valid(s_mem_valid), .s_mem_rdata(s_mem_rdata), .s_mem_error(s_mem_error),
    .m_mem_req(m_mem_req), .m_mem_gnt(m_mem_gnt), .m_mem_addr(m_mem_addr),
    .m_mem_wdata(m_mem_wdata), .m_mem_we(m_mem_we), .m_mem_be(m_mem_be),
    .m_mem_valid(m_mem_valid), .m_mem_rdata(m_mem_rdata), .m_mem_error(m_mem_error),
    .busy_o(busy_o), .spurious_rsp_o(spurious_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] port_addr(int i);
    return i == 2 ? 64'h8000_1000 : 64'(32'h1000 * (i + 1));
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    s_mem_req = '0; m_mem_gnt = 0; m_mem_valid = 0; m_mem_error = 0; m_mem_rdata = '0;
  endtask

  task automatic pulse_reset();
    rst_ni = 0;
    #2;
    rst_ni = 1;
  endtask

  initial begin
    rst_ni = 0;
    idle();
    s_mem_we = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      s_mem_addr[i*64 +: 64]  = port_addr(i);
      s_mem_wdata[i*64 +: 64] = 64'hA0 + 64'(i);
      s_mem_be[i*8 +: 8]      = 8'hF0 | 8'(i);
    end
    #12;
    chk("rst_m_req", 64'(m_mem_req), 0);
    chk("rst_s_gnt", 64'(s_mem_gnt), 0);
    chk("rst_m_addr", m_mem_addr, 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_spur", 64'(spurious_rsp_o), 0);
    rst_ni = 1;

    // single port 2
    nxt();
    s_mem_req = 4'b0100; m_mem_gnt = 1;
    #2;
    chk("t1_m_req", 64'(m_mem_req), 1);
    chk("t1_addr", m_mem_addr, 64'h8000_1000);
    chk("t1_wdata", m_mem_wdata, 64'hA2);
    chk("t1_we", 64'(m_mem_we), 1);
    chk("t1_be", 64'(m_mem_be), 64'hF2);
    chk("t1_gnt", 64'(s_mem_gnt), 4'b0100);
    nxt();
    idle(); m_mem_valid = 1; m_mem_rdata = 64'hDEAD_BEEF;
    #2;
    chk("t1_valid", 64'(s_mem_valid), 4'b0100);
    chk("t1_rdata", s_mem_rdata, 64'hDEAD_BEEF);
    chk("t1_err", 64'(s_mem_error), 0);
    chk("t1_busy", 64'(busy_o), 1);
    nxt();
    idle();
    #2;
    chk("t1_idle_busy", 64'(busy_o), 0);
    chk("t1_idle_valid", 64'(s_mem_valid), 0);

    // round robin from rr_ptr=0 with all ports requesting
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      nxt();
      s_mem_req = 4'b1111; m_mem_gnt = 1; m_mem_valid = (k > 0);
      #2;
      chk($sformatf("t2_gnt%0d", k), 64'(s_mem_gnt), 64'(4'b0001 << (k % 4)));
      chk($sformatf("t2_addr%0d", k), m_mem_addr, port_addr(k % 4));
      chk($sformatf("t2_valid%0d", k), 64'(s_mem_valid), k > 0 ? 64'(4'b0001 << ((k - 1) % 4)) : 0);
    end
    nxt();
    idle(); m_mem_valid = 1;
    #2;
    chk("t2_last_valid", 64'(s_mem_valid), 4'b0001);
    nxt();
    idle();

    // lock: port 1 stalled, port 0 joins, rr_ptr=0 would otherwise favour port 0
    pulse_reset();
    nxt();
    s_mem_req = 4'b0010;
    #2;
    chk("t3_addr0", m_mem_addr, port_addr(1));
    chk("t3_gnt0", 64'(s_mem_gnt), 0);
    nxt();
    nxt();
    s_mem_req = 4'b0011;
    #2;
    chk("t3_addr_locked", m_mem_addr, port_addr(1));
    chk("t3_busy_lock", 64'(busy_o), 1);
    nxt();
    m_mem_gnt = 1;
    #2;
    chk("t3_gnt_p1", 64'(s_mem_gnt), 4'b0010);
    nxt();
    s_mem_req = 4'b0001;
    #2;
    chk("t3_gnt_p0", 64'(s_mem_gnt), 4'b0001);
    nxt();
    idle(); m_mem_valid = 1;
    #2;
    chk("t3_rsp_p1", 64'(s_mem_valid), 4'b0010);
    nxt();
    #2;
    chk("t3_rsp_p0", 64'(s_mem_valid), 4'b0001);

    // full FIFO: rr_ptr=1 now, so port 3 then port 0
    nxt();
    idle(); s_mem_req = 4'b1000; m_mem_gnt = 1;
    #2;
    chk("t4_gnt_p3", 64'(s_mem_gnt), 4'b1000);
    nxt();
    s_mem_req = 4'b0001;
    #2;
    chk("t4_gnt_p0", 64'(s_mem_gnt), 4'b0001);
    nxt();
    s_mem_req = 4'b0010;
    #2;
    chk("t4_full_req", 64'(m_mem_req), 0);
    chk("t4_full_gnt", 64'(s_mem_gnt), 0);
    nxt();
    m_mem_valid = 1; m_mem_error = 1;
    #2;
    chk("t4_valid_p3", 64'(s_mem_valid), 4'b1000);
    chk("t4_err_p3", 64'(s_mem_error), 4'b1000);
    chk("t4_no_pushthru", 64'(m_mem_req), 0);
    nxt();
    m_mem_error = 0;
    #2;
    chk("t4_valid_p0", 64'(s_mem_valid), 4'b0001);
    chk("t4_err_p0", 64'(s_mem_error), 0);
    chk("t4_gnt_p1", 64'(s_mem_gnt), 4'b0010);
    nxt();
    idle();
    #2;
    chk("t4_occ_busy", 64'(busy_o), 1);
    m_mem_valid = 1;
    #1;
    chk("t4_valid_p1", 64'(s_mem_valid), 4'b0010);
    nxt();
    idle();
    #2;
    chk("t4_drained", 64'(busy_o), 0);

    // spurious response and asynchronous reset mid-transaction
    m_mem_valid = 1; m_mem_rdata = 64'h1234;
    #1;
    chk("t6_spur_valid", 64'(s_mem_valid), 0);
    chk("t6_spur_pre", 64'(spurious_rsp_o), 0);
    nxt();
    idle();
    #2;
    chk("t6_spur_set", 64'(spurious_rsp_o), 1);
    nxt();
    s_mem_req = 4'b0100;
    #2;
    chk("t6_spur_held", 64'(spurious_rsp_o), 1);
    nxt();
    #2;
    chk("t6_lock_busy", 64'(busy_o), 1);
    idle();
    rst_ni = 0;
    #1;
    chk("t6_rst_busy", 64'(busy_o), 0);
    chk("t6_rst_spur", 64'(spurious_rsp_o), 0);
    chk("t6_rst_m_req", 64'(m_mem_req), 0);
    chk("t6_rst_addr", m_mem_addr, 0);
    chk("t6_rst_gnt", 64'(s_mem_gnt), 0);
    rst_ni = 1;
    nxt();
    m_mem_valid = 1;
    #2;
    chk("t6_post_valid", 64'(s_mem_valid), 0);
    nxt();
    idle();
    #2;
    chk("t6_post_spur", 64'(spurious_rsp_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
